// File: rtl/ro_pair_evaluator.sv
// Purpose : PUF response stage that compares the edge counts of two selected ring oscillators.
// Latency : done pulses SETTLE+WINDOW+2 clk after the start-sampling edge
//           (3*(SETTLE+WINDOW+1)+1 clk with RO_PAIR_MAJORITY_EN defined).
// Backpr. : none; start is only accepted in IDLE, and a start while busy is dropped, not queued.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start, challenge    evaluation request; challenge[2:0] selects osc A, [5:3] selects osc B
//   sel_a, sel_b        registered select lines to the two 8:1 oscillator muxes
//   ro_a, ro_b          mux outputs, asynchronous to clk
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle pulse once response/tie/count_a/count_b are valid
//   response, tie       count_a > count_b, count_a == count_b
//   count_a, count_b    final (saturating) edge counts
//
// Optional feature macro: RO_PAIR_MAJORITY_EN
//   Undefined (default): one SETTLE/MEASURE/COMPARE round per evaluation.
//   Defined: three rounds with the same selects; response is the majority of the
//   per-round (a > b) bits, tie only if all three rounds tied, counts show the last round.

module ro_pair_evaluator #(
  parameter int CNT_WIDTH = 16,
  parameter int WINDOW    = 1024,
  parameter int SETTLE    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [5:0]           challenge,
  output logic [2:0]           sel_a,
  output logic [2:0]           sel_b,
  input  logic                 ro_a,
  input  logic                 ro_b,
  output logic                 busy,
  output logic                 done,
  output logic                 response,
  output logic                 tie,
  output logic [CNT_WIDTH-1:0] count_a,
  output logic [CNT_WIDTH-1:0] count_b
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_COMPARE = 3'd3,
    ST_REPORT  = 3'd4
  } state_t;

  // The timer is loaded with (length - 1) and the state advances on the cycle it
  // reads zero, so each timed state lasts exactly its configured number of cycles.
  localparam logic [15:0]          SETTLE_LD = 16'(SETTLE - 1);
  localparam logic [15:0]          WINDOW_LD = 16'(WINDOW - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               state;
  logic [15:0]          timer;
  logic [CNT_WIDTH-1:0] cnt_a;
  logic [CNT_WIDTH-1:0] cnt_b;

  // ---------------------------------------------------------------------------
  // Oscillator conditioning: two-flop synchronizer plus one delay flop for the
  // rising-edge detector. Runs in every state so the detector history is always
  // current when a window opens.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic       sync_a_d;
  logic       sync_b_d;
  logic       rise_a;
  logic       rise_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a   <= 2'b00;
      sync_b   <= 2'b00;
      sync_a_d <= 1'b0;
      sync_b_d <= 1'b0;
    end else begin
      sync_a   <= {sync_a[0], ro_a};
      sync_b   <= {sync_b[0], ro_b};
      sync_a_d <= sync_a[1];
      sync_b_d <= sync_b[1];
    end
  end

  assign rise_a = sync_a[1] & ~sync_a_d;
  assign rise_b = sync_b[1] & ~sync_b_d;

  // Comparison of the live counters, used in COMPARE.
  logic cmp_gt;
  logic cmp_eq;

  assign cmp_gt = (cnt_a > cnt_b);
  assign cmp_eq = (cnt_a == cnt_b);

`ifdef RO_PAIR_MAJORITY_EN
  // Round index 0..2 and the recorded results of rounds 0 and 1; the third
  // round's result is used directly from the comparator.
  logic [1:0] round;
  logic [1:0] votes_gt;
  logic [1:0] votes_eq;
  logic       maj_gt;
  logic       all_eq;

  assign maj_gt = (votes_gt[0] & votes_gt[1]) |
                  (votes_gt[0] & cmp_gt)      |
                  (votes_gt[1] & cmp_gt);
  assign all_eq = votes_eq[0] & votes_eq[1] & cmp_eq;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. done is raised on the edge that leaves
  // REPORT, so it is visible during the first IDLE cycle; a start held high in
  // that cycle is accepted immediately.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= 16'd0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      sel_a    <= 3'd0;
      sel_b    <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= 1'b0;
      tie      <= 1'b0;
      count_a  <= '0;
      count_b  <= '0;
`ifdef RO_PAIR_MAJORITY_EN
      round    <= 2'd0;
      votes_gt <= 2'b00;
      votes_eq <= 2'b00;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_a <= challenge[2:0];
            sel_b <= challenge[5:3];
            cnt_a <= '0;
            cnt_b <= '0;
            timer <= SETTLE_LD;
            busy  <= 1'b1;
            state <= ST_SETTLE;
`ifdef RO_PAIR_MAJORITY_EN
            round    <= 2'd0;
            votes_gt <= 2'b00;
            votes_eq <= 2'b00;
`endif
          end
        end

        // Mux outputs are still settling after a select change; edges are ignored.
        ST_SETTLE: begin
          if (timer == 16'd0) begin
            timer <= WINDOW_LD;
            state <= ST_MEASURE;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        // Saturating counts: a counter at all-ones holds rather than wrapping, so
        // two saturated oscillators read as a tie instead of a random compare.
        ST_MEASURE: begin
          if (rise_a && (cnt_a != CNT_MAX)) begin
            cnt_a <= cnt_a + CNT_ONE;
          end
          if (rise_b && (cnt_b != CNT_MAX)) begin
            cnt_b <= cnt_b + CNT_ONE;
          end
          if (timer == 16'd0) begin
            state <= ST_COMPARE;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        ST_COMPARE: begin
`ifdef RO_PAIR_MAJORITY_EN
          if (round == 2'd2) begin
            count_a  <= cnt_a;
            count_b  <= cnt_b;
            response <= maj_gt;
            tie      <= all_eq;
            state    <= ST_REPORT;
          end else begin
            // Record this round and start the next one with the same selects.
            votes_gt[round[0]] <= cmp_gt;
            votes_eq[round[0]] <= cmp_eq;
            round <= round + 2'd1;
            cnt_a <= '0;
            cnt_b <= '0;
            timer <= SETTLE_LD;
            state <= ST_SETTLE;
          end
`else
          count_a  <= cnt_a;
          count_b  <= cnt_b;
          response <= cmp_gt;
          tie      <= cmp_eq;
          state    <= ST_REPORT;
`endif
        end

        ST_REPORT: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
